// File: rtl/serial_adder_responder.sv
// Bit-serial adder responder: receives a framed A/B operand stream, returns a
// framed WIDTH+1 bit sum, and reports busy, bad-stop pulses and a frame count.
module serial_adder_responder #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        input_signal,
  output logic        output_signal,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_OP  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_SUM = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RX_A,
    RX_B,
    RX_STOP,
    TX_START,
    TX_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             out_d;
  logic             err_d;
  logic             cnt_inc;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    out_d     = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (input_signal) begin
          state_d   = RX_A;
          bit_cnt_d = '0;
        end
      end
      RX_A: begin
        // Operands arrive LSB first, so shift in from the top.
        a_d = WIDTH'({input_signal, a_q} >> 1);
        if (bit_cnt_q == LAST_OP) begin
          state_d   = RX_B;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      RX_B: begin
        b_d = WIDTH'({input_signal, b_q} >> 1);
        if (bit_cnt_q == LAST_OP) begin
          state_d   = RX_STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (!input_signal) begin
          sum_d   = {1'b0, a_q} + {1'b0, b_q};
          cnt_inc = 1'b1;
          out_d   = 1'b1;
          state_d = TX_START;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_START: begin
        // The sum register is consumed as a shift register, LSB out first.
        out_d     = sum_q[0];
        sum_d     = sum_q >> 1;
        bit_cnt_d = '0;
        state_d   = TX_DATA;
      end
      TX_DATA: begin
        if (bit_cnt_q == LAST_SUM) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          out_d     = sum_q[0];
          sum_d     = sum_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and sum registers are reset too, so a frame cut short by
      // reset can never leak stale data into a later response.
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      output_signal <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sum_q         <= sum_d;
      output_signal <= out_d;
      busy          <= (state_d != IDLE);
      frame_err     <= err_d;
      if (cnt_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
